// File: rtl/uart_tx_frame_pkg.sv
// Shared UART definitions used by the transmit frame stage and its companion
// receiver.
//   tx_state_t         : frame state encoding (3 bits, IDLE=0 .. STOP=4)
//   UART_DEFAULT_*     : default frame format, 8 data bits, no parity, 1 stop bit
package uart_tx_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam int UART_DEFAULT_DATA_BITS  = 8;
  localparam int UART_DEFAULT_STOP_BITS  = 1;
  localparam int UART_DEFAULT_PARITY_EN  = 0;
  localparam int UART_DEFAULT_PARITY_ODD = 0;

endpackage

// File: rtl/uart_tx_frame.sv
// UART transmit frame stage. Serialises bytes into
// start / DATA_BITS data (LSB first) / optional parity / STOP_BITS stop bits,
// advancing one bit per baud_ena tick. A one-entry holding register lets the
// next byte be queued while the current frame shifts, so frames can run
// back-to-back without an idle bit.
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active-high
//   baud_ena   one-clk bit-period tick from the baud generator
//   tx_data    byte to send (low DATA_BITS bits)
//   tx_valid   tx_data valid; accepted when tx_valid && tx_ready
//   tx_ready   holding register empty
//   txd        serial line, idle high
//   busy       frame in progress or holding register full
//   frame_done one-clk pulse when the last stop bit period ends
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int DATA_BITS  = UART_DEFAULT_DATA_BITS,
  parameter int PARITY_EN  = UART_DEFAULT_PARITY_EN,
  parameter int PARITY_ODD = UART_DEFAULT_PARITY_ODD,
  parameter int STOP_BITS  = UART_DEFAULT_STOP_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_ena,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [3:0] DATA_BITS_CNT = 4'(DATA_BITS);
  localparam logic [1:0] STOP_CNT      = 2'(STOP_BITS);
  localparam logic       ODD_SEL       = 1'(PARITY_ODD);

  tx_state_t            state_reg, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] hold_data_reg, hold_data_next;
  logic                 hold_full_reg, hold_full_next;
  logic [3:0]           bit_cnt_reg, bit_cnt_next;
  logic [1:0]           stop_cnt_reg, stop_cnt_next;
  logic                 parity_reg, parity_next;
  logic                 txd_reg, txd_next;
  logic                 frame_done_reg, frame_done_next;
  logic                 load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      shift_reg      <= '0;
      hold_data_reg  <= '0;
      hold_full_reg  <= 1'b0;
      bit_cnt_reg    <= '0;
      stop_cnt_reg   <= '0;
      parity_reg     <= 1'b0;
      txd_reg        <= 1'b1;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shift_reg      <= shift_next;
      hold_data_reg  <= hold_data_next;
      hold_full_reg  <= hold_full_next;
      bit_cnt_reg    <= bit_cnt_next;
      stop_cnt_reg   <= stop_cnt_next;
      parity_reg     <= parity_next;
      txd_reg        <= txd_next;
      frame_done_reg <= frame_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    shift_next      = shift_reg;
    hold_data_next  = hold_data_reg;
    hold_full_next  = hold_full_reg;
    bit_cnt_next    = bit_cnt_reg;
    stop_cnt_next   = stop_cnt_reg;
    parity_next     = parity_reg;
    txd_next        = txd_reg;
    frame_done_next = 1'b0;
    load            = 1'b0;

    // Accept only into an empty holding register. A load needs it full, so
    // an accept and a load can never collide on the same edge.
    if (tx_valid && !hold_full_reg) begin
      hold_data_next = tx_data;
      hold_full_next = 1'b1;
    end

    if (baud_ena) begin
      case (state_reg)
        ST_IDLE: begin
          if (hold_full_reg) load = 1'b1;
        end
        ST_START: begin
          txd_next     = shift_reg[0];
          shift_next   = shift_reg >> 1;
          bit_cnt_next = 4'd1;
          state_next   = ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt_reg < DATA_BITS_CNT) begin
            txd_next     = shift_reg[0];
            shift_next   = shift_reg >> 1;
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (PARITY_EN != 0) begin
            txd_next   = parity_reg;
            state_next = ST_PARITY;
          end else begin
            txd_next      = 1'b1;
            stop_cnt_next = 2'd1;
            state_next    = ST_STOP;
          end
        end
        ST_PARITY: begin
          txd_next      = 1'b1;
          stop_cnt_next = 2'd1;
          state_next    = ST_STOP;
        end
        ST_STOP: begin
          if (stop_cnt_reg < STOP_CNT) begin
            stop_cnt_next = stop_cnt_reg + 2'd1;
          end else begin
            frame_done_next = 1'b1;
            // A queued byte starts immediately: its start bit replaces
            // what would otherwise be the first idle bit.
            if (hold_full_reg) load = 1'b1;
            else               state_next = ST_IDLE;
          end
        end
        default: begin
          txd_next   = 1'b1;
          state_next = ST_IDLE;
        end
      endcase
    end

    if (load) begin
      shift_next     = hold_data_reg;
      // Parity is fixed at load time from the byte as loaded.
      parity_next    = (^hold_data_reg) ^ ODD_SEL;
      hold_full_next = 1'b0;
      txd_next       = 1'b0;
      state_next     = ST_START;
    end
  end

  assign tx_ready   = !hold_full_reg;
  assign busy       = (state_reg != ST_IDLE) || hold_full_reg;
  assign txd        = txd_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame. Three instances cover 8N1, 8 data
// bits with even parity and 2 stop bits, and 7 data bits with odd parity.
// Expected line activity is built per frame from the frame format rules.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_ena;
  logic [7:0] tx_data;
  logic [2:0] tx_valid_v;
  wire  [2:0] ready_v, txd_v, busy_v, done_v;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  int cfg_db   [3] = '{8, 8, 7};
  int cfg_par  [3] = '{0, 1, 1};
  int cfg_odd  [3] = '{0, 0, 1};
  int cfg_stop [3] = '{1, 2, 1};

  byte unsigned bytes_q[$];
  bit           exp_bits[$];

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .baud_ena(baud_ena), .tx_data(tx_data),
    .tx_valid(tx_valid_v[0]), .tx_ready(ready_v[0]), .txd(txd_v[0]),
    .busy(busy_v[0]), .frame_done(done_v[0]));

  uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .baud_ena(baud_ena), .tx_data(tx_data),
    .tx_valid(tx_valid_v[1]), .tx_ready(ready_v[1]), .txd(txd_v[1]),
    .busy(busy_v[1]), .frame_done(done_v[1]));

  uart_tx_frame #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst(rst), .baud_ena(baud_ena), .tx_data(tx_data[6:0]),
    .tx_valid(tx_valid_v[2]), .tx_ready(ready_v[2]), .txd(txd_v[2]),
    .busy(busy_v[2]), .frame_done(done_v[2]));

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; baud_ena ticks every 4 clocks.
  task automatic clk_step();
    @(negedge clk);
    cyc++;
    baud_ena = (cyc % 4 == 0);
  endtask

  // Line bits for every byte in bytes_q, plus one trailing idle bit.
  // Returns the frame length in bit periods.
  function automatic int build_expected(input int inst);
    byte unsigned b;
    int ones;
    exp_bits.delete();
    foreach (bytes_q[j]) begin
      b = bytes_q[j];
      ones = 0;
      exp_bits.push_back(1'b0);
      for (int i = 0; i < cfg_db[inst]; i++) begin
        exp_bits.push_back(b[i]);
        ones += int'(b[i]);
      end
      if (cfg_par[inst] != 0) exp_bits.push_back(1'((ones % 2) ^ cfg_odd[inst]));
      for (int s = 0; s < cfg_stop[inst]; s++) exp_bits.push_back(1'b1);
    end
    exp_bits.push_back(1'b1);
    return 1 + cfg_db[inst] + cfg_par[inst] + cfg_stop[inst];
  endfunction

  // Offer bytes_q to one instance as fast as it accepts them and check the
  // line at every clock. Bits are recorded at the ticks after the first
  // accept; abort_at >= 0 returns once that many bits have been recorded.
  task automatic run_stream(input int inst, input string tag, input int abort_at);
    int L, total, sent, rec, guard;
    bit in_rec, was_rec, acc, tick;
    logic last_bit;
    L = build_expected(inst);
    total = exp_bits.size() - 1;
    sent = 0; rec = 0; guard = 0; in_rec = 1'b0; last_bit = 1'b1;
    while (rec <= total) begin
      if (guard > 3000) begin
        check_int({tag, "_timeout"}, rec, total + 1);
        break;
      end
      tx_valid_v = '0;
      if (sent < bytes_q.size()) begin
        tx_valid_v[inst] = 1'b1;
        // While stalled, scramble the data: it must not be sampled.
        tx_data = ready_v[inst] ? bytes_q[sent] : 8'($urandom);
      end else begin
        tx_data = 8'($urandom);
      end
      acc  = tx_valid_v[inst] && ready_v[inst];
      tick = baud_ena;
      clk_step();
      guard++;
      if (acc) sent++;
      was_rec = in_rec;
      if (acc) in_rec = 1'b1;
      if (was_rec && tick) begin
        check_bit($sformatf("%s_txd%0d", tag, rec), txd_v[inst], exp_bits[rec]);
        check_bit($sformatf("%s_done%0d", tag, rec), done_v[inst], (rec > 0) && (rec % L == 0));
        check_bit($sformatf("%s_busy%0d", tag, rec), busy_v[inst], rec < total);
        if ((rec % L == 0) && (rec < total))
          check_bit($sformatf("%s_ready_load%0d", tag, rec), ready_v[inst], 1'b1);
        last_bit = exp_bits[rec];
        rec++;
        if (abort_at >= 0 && rec == abort_at) return;
      end else begin
        check_bit({tag, "_txd_hold"}, txd_v[inst], last_bit);
        check_bit({tag, "_done_quiet"}, done_v[inst], 1'b0);
        check_bit({tag, "_busy"}, busy_v[inst], in_rec);
      end
    end
    tx_valid_v = '0;
  endtask

  initial begin
    rst        = 1'b1;
    baud_ena   = 1'b0;
    tx_data    = 8'h00;
    tx_valid_v = '0;

    // Reset held for 3 clocks, then idle with ticks running.
    for (int i = 0; i < 3; i++) clk_step();
    for (int k = 0; k < 3; k++) begin
      check_bit($sformatf("rst_txd%0d", k), txd_v[k], 1'b1);
      check_bit($sformatf("rst_ready%0d", k), ready_v[k], 1'b1);
      check_bit($sformatf("rst_busy%0d", k), busy_v[k], 1'b0);
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      clk_step();
      for (int k = 0; k < 3; k++) begin
        check_bit($sformatf("idle_txd%0d", k), txd_v[k], 1'b1);
        check_bit($sformatf("idle_ready%0d", k), ready_v[k], 1'b1);
        check_bit($sformatf("idle_busy%0d", k), busy_v[k], 1'b0);
        check_bit($sformatf("idle_done%0d", k), done_v[k], 1'b0);
      end
    end

    bytes_q = '{8'hA5};
    run_stream(0, "a5_8n1", -1);
    $display("txn a5_8n1 done: compared=%0d", compared);

    bytes_q = '{8'h00, 8'hFF};
    run_stream(0, "b2b_00_ff", -1);
    $display("txn b2b_00_ff done: compared=%0d", compared);

    bytes_q = '{8'h07};
    run_stream(1, "par_even_2stop_07", -1);
    $display("txn par_even_2stop_07 done: compared=%0d", compared);

    bytes_q = '{8'h07};
    run_stream(2, "par_odd_07", -1);
    $display("txn par_odd_07 done: compared=%0d", compared);

    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        bytes_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
        run_stream(k, $sformatf("flow_i%0d_r%0d", k, r), -1);
        $display("txn flow inst=%0d round=%0d bytes=%02h %02h %02h compared=%0d",
                 k, r, bytes_q[0], bytes_q[1], bytes_q[2], compared);
      end
    end

    // Reset in the middle of data bit 3 with a second byte still queued.
    bytes_q = '{8'hA5, 8'h3C};
    run_stream(0, "pre_rst", 5);
    tx_valid_v = '0;
    #3;
    rst = 1'b1;
    #1;
    check_bit("midrst_txd", txd_v[0], 1'b1);
    check_bit("midrst_busy", busy_v[0], 1'b0);
    check_bit("midrst_ready", ready_v[0], 1'b1);
    check_bit("midrst_done", done_v[0], 1'b0);
    clk_step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      clk_step();
      check_bit("postrst_txd", txd_v[0], 1'b1);
      check_bit("postrst_busy", busy_v[0], 1'b0);
    end
    bytes_q = '{8'h5A};
    run_stream(0, "fresh_after_rst", -1);
    $display("txn mid_frame_reset done: compared=%0d", compared);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Serial transmit stage downstream of the UART baud generator.
- Consumes the generator's one-clock `ena` tick (one tick per bit period) and parallel bytes from the acquisition/command logic via a valid/ready handshake.
- Drives the UART TXD line with 1 start bit, DATA_BITS data bits (LSB first), optional parity, and STOP_BITS stop bits.
- A one-entry holding register allows back-to-back frames with no idle gap.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 1 selects odd parity, 0 selects even; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- baud_ena  in  1  bit-period tick from the baud generator, one clk wide
- tx_data  in  DATA_BITS  byte to send; only the low DATA_BITS bits are used
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  holding register empty; the byte is accepted when tx_valid && tx_ready
- txd  out  1  serial line, idle high
- busy  out  1  a frame is in progress or the holding register is full
- frame_done  out  1  one-clk pulse when the last stop bit period ends

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, holding register empty, txd=1, tx_ready=1, busy=0, frame_done=0.
  - Reset applied mid-frame aborts the frame; txd returns to 1 immediately (asynchronous).
- Holding register:
  - tx_ready = !hold_full, combinational from the register.
  - An accept writes hold_data and sets hold_full on the same clk edge.
  - hold_full clears on the clk edge where the shifter loads from it.
  - An accept in the same cycle as a load is impossible, since tx_ready=0 then.
- State machine (registered):
  - States: IDLE, START, DATA, PARITY, STOP.
  - All transitions happen only on clk edges where baud_ena=1.
  - IDLE: if hold_full at a baud_ena, load the shifter from the holding register, clear hold_full, txd<=0, go to START. Otherwise txd stays 1.
  - START: at baud_ena, txd<=shift[0], shift right, bit_cnt<=1, go to DATA.
  - DATA:
    - At baud_ena, if bit_cnt<DATA_BITS: txd<=shift[0], shift, bit_cnt++.
    - Otherwise go to PARITY if PARITY_EN, else go to STOP with txd<=1 and stop_cnt<=1.
  - PARITY:
    - The bit is computed on the loaded byte: even parity = XOR of the data bits; odd parity = its inverse.
    - txd takes the parity value on entry; at the next baud_ena go to STOP with txd<=1.
  - STOP:
    - At baud_ena, if stop_cnt<STOP_BITS: stop_cnt++, txd stays 1.
    - Otherwise pulse frame_done=1 for one clk.
    - If hold_full at that same edge, load the next byte, txd<=0, go to START (back-to-back, no idle bit). Otherwise go to IDLE.
- Timing:
  - Each bit is held for exactly one baud_ena interval.
  - Latency from accept to the start-bit edge is up to one baud_ena interval, because the frame always begins on a tick.
- Outputs:
  - busy = (state!=IDLE) || hold_full.
- Boundary cases:
  - tx_valid with tx_ready=0: the input is held by the source and not sampled; no overwrite of hold_data.
  - A baud_ena tick that is wider than one clk is not supported; each high cycle counts as a tick.
  - baud_ena is ignored for data sampling; tx_data changing after accept has no effect.
- Widths: bit_cnt is 4 bits; stop_cnt is 2 bits; the shifter is DATA_BITS wide.

Decomposition:
- Shared uart package holds:
  - state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit);
  - the default frame constants (8 data bits, 1 stop bit, no parity), reused by the companion receiver.
- No sub-module needed. The parity XOR is a single expression; the holding register and FSM stay in one file.

Test Plan:
- Reset idle: rst=1 for 3 clks, then 0, with baud_ena every 4 clks -> txd=1, tx_ready=1, busy=0, frame_done never pulses.
- Single byte 0xA5, 8N1, baud_ena every 4 clks:
  - txd sequence per tick is 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop).
  - frame_done pulses once at the end of the stop bit.
  - tx_ready returns to 1 on the load edge.
- Back-to-back 0x00 then 0xFF:
  - second byte accepted while the first is shifting;
  - the start bit of 0xFF follows the stop of 0x00 with no extra idle tick;
  - two frame_done pulses, 10 ticks apart.
- Parity, PARITY_EN=1:
  - PARITY_ODD=0 with 0x07 -> parity bit 1;
  - PARITY_ODD=1 with 0x07 -> 0;
  - STOP_BITS=2 -> two high stop ticks, 12 ticks per frame.
- Flow control: hold tx_valid=1 with 3 queued bytes -> tx_ready drops after each accept, no byte lost or duplicated, serial output matches the input order.
- Mid-frame reset: assert rst during data bit 3 -> txd=1 asynchronously, state IDLE, holding register empty, next accepted byte sent as a complete fresh frame.
